// File: rtl/picosoc_iomem_decoder_if.sv
// CPU-side native memory bus (valid/ready handshake) of the iomem decoder.
// master = CPU, slave = decoder.
interface picosoc_iomem_decoder_if;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/picosoc_iomem_decoder.sv
// iomem decoder: maps 16 MB pages above BASE_PAGE onto NUM_SLOTS peripheral slots with a bus timeout.
// Optional sticky error capture (err_irq/err_addr/err_clear) enabled by defining PICOSOC_IOMEM_ERR_EN.
module picosoc_iomem_decoder #(
    parameter int          NUM_SLOTS      = 4,
    parameter logic [7:0]  BASE_PAGE      = 8'h03,
    parameter int          TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic                   clk,
    input  logic                   reset,
    picosoc_iomem_decoder_if.slave bus,
    output logic [NUM_SLOTS-1:0]   slot_valid,
    input  logic [NUM_SLOTS-1:0]   slot_ready,
    output logic [31:0]            slot_addr,
    output logic [31:0]            slot_wdata,
    output logic [3:0]             slot_wstrb,
    input  logic [32*NUM_SLOTS-1:0] slot_rdata,
    input  logic                   err_clear,
    output logic                   err_irq,
    output logic [31:0]            err_addr
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t         state;
    logic [15:0]    counter;
    logic           mem_ready_q;
    logic [31:0]    mem_rdata_q;

    logic [8:0]           page_off;
    logic                 in_window;
    logic                 mapped;
    logic [NUM_SLOTS-1:0] req_onehot;
    logic                 hit;
    logic                 timeout;
    logic [31:0]          sel_rdata;

    assign bus.mem_ready = mem_ready_q;
    assign bus.mem_rdata = mem_rdata_q;

    // Ninth bit of page_off is the borrow: set when the page lies below BASE_PAGE.
    always_comb begin
        page_off   = {1'b0, bus.mem_addr[31:24]} - {1'b0, BASE_PAGE};
        in_window  = !page_off[8] && (page_off[7:4] == 4'd0);
        mapped     = in_window && ({1'b0, page_off[3:0]} < 5'(NUM_SLOTS));
        req_onehot = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            req_onehot[k] = (page_off[3:0] == 4'(k));
        end
    end

    // slot_valid is one-hot while in ACCESS, so it doubles as the slot select.
    always_comb begin
        sel_rdata = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (slot_valid[k]) begin
                sel_rdata = sel_rdata | slot_rdata[32*k +: 32];
            end
        end
        hit     = |(slot_ready & slot_valid);
        timeout = (state == ACCESS) && !hit && (counter == 16'(TIMEOUT_CYCLES - 1));
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            counter     <= '0;
            mem_ready_q <= 1'b0;
            mem_rdata_q <= '0;
            slot_valid  <= '0;
            slot_addr   <= '0;
            slot_wdata  <= '0;
            slot_wstrb  <= '0;
        end else begin
            mem_ready_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.mem_valid && in_window) begin
                        if (mapped) begin
                            slot_addr  <= bus.mem_addr;
                            slot_wdata <= bus.mem_wdata;
                            slot_wstrb <= bus.mem_wstrb;
                            slot_valid <= req_onehot;
                            counter    <= '0;
                            state      <= ACCESS;
                        end else begin
                            mem_rdata_q <= ERR_RDATA;
                            mem_ready_q <= 1'b1;
                            state       <= RESP;
                        end
                    end
                end
                ACCESS: begin
                    if (counter != 16'hFFFF) begin
                        counter <= counter + 16'd1;
                    end
                    if (hit) begin
                        mem_rdata_q <= sel_rdata;
                        mem_ready_q <= 1'b1;
                        slot_valid  <= '0;
                        state       <= RESP;
                    end else if (timeout) begin
                        mem_rdata_q <= ERR_RDATA;
                        mem_ready_q <= 1'b1;
                        slot_valid  <= '0;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef PICOSOC_IOMEM_ERR_EN
    logic        err_set;
    logic [31:0] err_src;

    assign err_set = ((state == IDLE) && bus.mem_valid && in_window && !mapped) || timeout;
    assign err_src = (state == IDLE) ? bus.mem_addr : slot_addr;

    // A new error outranks a same-cycle clear; only the first failing address is kept.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_irq  <= 1'b0;
            err_addr <= '0;
        end else begin
            if (err_set) begin
                err_irq <= 1'b1;
                if (!err_irq) begin
                    err_addr <= err_src;
                end
            end else if (err_clear) begin
                err_irq <= 1'b0;
            end
        end
    end
`else
    logic unused_err_clear;

    assign unused_err_clear = err_clear;
    assign err_irq          = 1'b0;
    assign err_addr         = '0;
`endif

endmodule

// File: tb/tb_picosoc_iomem_decoder.sv
// Scoreboard bench for picosoc_iomem_decoder (NUM_SLOTS=4, TIMEOUT_CYCLES=8).
// Expected responses are queued when a request is issued and popped when mem_ready fires.
module tb_picosoc_iomem_decoder;

    localparam int          NS  = 4;
    localparam int          TO  = 8;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;
`ifdef PICOSOC_IOMEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NS-1:0]     slot_valid;
    logic [NS-1:0]     slot_ready = '0;
    logic [31:0]       slot_addr;
    logic [31:0]       slot_wdata;
    logic [3:0]        slot_wstrb;
    logic [32*NS-1:0]  slot_rdata = '0;
    logic              err_clear = 1'b0;
    logic              err_irq;
    logic [31:0]       err_addr;

    picosoc_iomem_decoder_if bus ();

    picosoc_iomem_decoder #(
        .NUM_SLOTS      (NS),
        .BASE_PAGE      (8'h03),
        .TIMEOUT_CYCLES (TO),
        .ERR_RDATA      (ERR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .slot_valid (slot_valid),
        .slot_ready (slot_ready),
        .slot_addr  (slot_addr),
        .slot_wdata (slot_wdata),
        .slot_wstrb (slot_wstrb),
        .slot_rdata (slot_rdata),
        .err_clear  (err_clear),
        .err_irq    (err_irq),
        .err_addr   (err_addr)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_passed = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_rdata = '0;
    bit          exp_irq = 1'b0;
    logic [31:0] exp_err_addr = '0;
    logic        prev_ready = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void note_error(input logic [31:0] addr);
        if (ERR_EN) begin
            if (!exp_irq) exp_err_addr = addr;
            exp_irq = 1'b1;
        end
    endfunction

    // Response monitor: every mem_ready pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && bus.mem_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ready", 32'd1, 32'd0);
            end else begin
                check("rdata", bus.mem_rdata, exp_q.pop_front());
            end
            check("ready_pulse", {31'd0, prev_ready}, 32'd0);
        end
        prev_ready = bus.mem_ready;
    end

    // Mapped access; delay = ACCESS cycle index of slot_ready (negative = never).
    task automatic access(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                          input int slot, input int delay, input logic [31:0] rdata);
        logic [NS-1:0] oh;
        bit            to;
        oh = '0;
        oh[slot] = 1'b1;
        to = (delay < 0) || (delay >= TO);
        for (int k = 0; k < NS; k++) slot_rdata[32*k +: 32] = 32'hBAD0_0000 | 32'(k);
        slot_rdata[32*slot +: 32] = rdata;
        last_rdata = to ? ERR : rdata;
        exp_q.push_back(last_rdata);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
        bus.mem_wstrb = wstrb;
        tick();
        for (int c = 0; c < TO; c++) begin
            slot_ready = (c == delay) ? '1 : ~oh;
            @(negedge clk);
            check("slot_valid", 32'(slot_valid), 32'(oh));
            check("slot_addr", slot_addr, addr);
            check("slot_wdata", slot_wdata, wdata);
            check("slot_wstrb", 32'(slot_wstrb), 32'(wstrb));
            check("mem_ready_busy", 32'(bus.mem_ready), 32'd0);
            tick();
            slot_ready = '0;
            if (c == delay) break;
        end
        bus.mem_valid = 1'b0;
        if (to) note_error(addr);
        @(negedge clk);
        check("mem_ready", 32'(bus.mem_ready), 32'd1);
        check("slot_valid_resp", 32'(slot_valid), 32'd0);
        check("err_irq", 32'(err_irq), 32'(exp_irq));
        check("err_addr", err_addr, exp_err_addr);
        tick();
        @(negedge clk);
        check("rdata_hold", bus.mem_rdata, last_rdata);
        check("ready_idle", 32'(bus.mem_ready), 32'd0);
    endtask

    // In-window page without a slot; clr drives err_clear in the same cycle.
    task automatic unmapped(input logic [31:0] addr, input bit clr);
        exp_q.push_back(ERR);
        last_rdata = ERR;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = addr;
        bus.mem_wstrb = 4'b0000;
        err_clear     = clr;
        tick();
        err_clear = 1'b0;
        note_error(addr);
        @(negedge clk);
        check("unmapped_ready", 32'(bus.mem_ready), 32'd1);
        check("unmapped_slot_valid", 32'(slot_valid), 32'd0);
        check("unmapped_err_irq", 32'(err_irq), 32'(exp_irq));
        check("unmapped_err_addr", err_addr, exp_err_addr);
        bus.mem_valid = 1'b0;
        tick();
    endtask

    task automatic outside(input logic [31:0] addr);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = addr;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("outside_slot_valid", 32'(slot_valid), 32'd0);
            check("outside_ready", 32'(bus.mem_ready), 32'd0);
            tick();
        end
        bus.mem_valid = 1'b0;
    endtask

    initial begin
        logic [NS-1:0] oh3;
        bus.mem_valid = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = '0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_mem_ready", 32'(bus.mem_ready), 32'd0);
        check("rst_mem_rdata", bus.mem_rdata, 32'd0);
        check("rst_slot_valid", 32'(slot_valid), 32'd0);
        check("rst_slot_addr", slot_addr, 32'd0);
        check("rst_err_irq", 32'(err_irq), 32'd0);
        check("rst_err_addr", err_addr, 32'd0);
        reset = 1'b0;
        tick();

        access(32'h0300_0010, 32'h0, 4'b0000, 0, 0, 32'h1234_5678);
        access(32'h0400_0004, 32'hCAFE_F00D, 4'b0011, 1, 5, 32'h0BAD_C0DE);
        access(32'h0600_00FC, 32'h0, 4'b0000, 3, TO - 1, 32'h5A5A_A5A5);
        access(32'h0500_0000, 32'h0, 4'b0000, 2, -1, 32'h7777_7777);

        unmapped(32'h0900_0000, 1'b0);
        unmapped(32'h1200_0000, 1'b1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        if (ERR_EN) exp_irq = 1'b0;
        @(negedge clk);
        check("clear_err_irq", 32'(err_irq), 32'(exp_irq));
        check("clear_err_addr", err_addr, exp_err_addr);
        tick();
        unmapped(32'h0A00_0000, 1'b0);

        outside(32'h0100_0000);
        outside(32'h0200_0000);
        outside(32'h1300_0000);
        access(32'h0300_0020, 32'h0, 4'b0000, 0, 2, 32'h0101_0101);

        // Reset during the third ACCESS cycle drops the access without a response.
        oh3 = '0;
        oh3[3] = 1'b1;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 32'h0600_0000;
        bus.mem_wstrb = 4'b0000;
        repeat (3) tick();
        reset = 1'b1;
        @(negedge clk);
        check("pre_reset_slot_valid", 32'(slot_valid), 32'(oh3));
        tick();
        reset = 1'b0;
        bus.mem_valid = 1'b0;
        exp_irq = 1'b0;
        exp_err_addr = '0;
        @(negedge clk);
        check("post_reset_slot_valid", 32'(slot_valid), 32'd0);
        check("post_reset_ready", 32'(bus.mem_ready), 32'd0);
        check("post_reset_err_irq", 32'(err_irq), 32'd0);
        repeat (2) tick();
        access(32'h0300_0000, 32'h0, 4'b0000, 0, 1, 32'hFEED_0001);

        repeat (2) tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
